// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared defaults and saturating-increment helper for the pattern detector
package seq_det_pkg;
    localparam int N_DEF = 4;
    localparam int CW_DEF = 8;
    localparam logic [3:0] DEF_PAT_DEF = 4'b1101;
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int w);
        logic [31:0] max;
        max = (w >= 32) ? '1 : (32'd1 << w) - 32'd1;
        return (cnt >= max) ? max : cnt + 32'd1;
    endfunction
endpackage

// File: rtl/seq_det_sat_cnt.sv
// seq_det_sat_cnt: saturating match counter with sticky saturation flag
//  clk, rst (sync, active-high), inc -> cnt[CW-1:0], sat
module seq_det_sat_cnt import seq_det_pkg::*; #(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          sat
);
    logic [CW-1:0] nxt;
    assign nxt = inc ? CW'(sat_inc(32'(cnt), CW)) : cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            sat <= 1'b0;
        end else begin
            cnt <= nxt;
            sat <= sat | (&nxt);
        end
    end
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector with loadable pattern, overlap mode and match counter
//  in : clk, rst (sync, active-high), en, x, pat_load, pat_in[N-1:0] (MSB oldest), overlap
//  out: y (one-cycle match pulse), match_cnt[CW-1:0] (saturating), cnt_sat (sticky)
module seq_detector_param import seq_det_pkg::*; #(
    parameter int N = N_DEF,
    parameter logic [N-1:0] DEF_PAT = N'(DEF_PAT_DEF),
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          x,
    input  logic          pat_load,
    input  logic [N-1:0]  pat_in,
    input  logic          overlap,
    output logic          y,
    output logic [CW-1:0] match_cnt,
    output logic          cnt_sat
);
    localparam int FW = $clog2(N + 1);
    logic [N-1:0]  pattern, hist, nh;
    logic [FW-1:0] fill, nf;
    logic          hit;
    assign nh  = {hist[N-2:0], x};
    assign nf  = (fill == FW'(N)) ? fill : fill + FW'(1);
    // a bit presented alongside pat_load is discarded, so it can never complete a match
    assign hit = en && !pat_load && (nf == FW'(N)) && (nh == pattern);
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern <= DEF_PAT;
            hist    <= '0;
            fill    <= '0;
            y       <= 1'b0;
        end else if (pat_load) begin
            pattern <= pat_in;
            hist    <= '0;
            fill    <= '0;
            y       <= 1'b0;
        end else if (en) begin
            hist <= nh;
            y    <= hit;
            // non-overlapping mode restarts the window from empty after a hit
            fill <= hit ? (overlap ? FW'(N) : '0) : nf;
        end else begin
            y <= 1'b0;
        end
    end
    seq_det_sat_cnt #(.CW(CW)) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit),
        .cnt (match_cnt),
        .sat (cnt_sat)
    );
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed self-checking bench for seq_detector_param
module tb_seq_detector_param;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       x = 1'b0;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'b0000;
    logic       overlap = 1'b1;
    logic       y, cnt_sat, y2, cnt_sat2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;
    int         total = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    seq_detector_param dut (
        .clk(clk), .rst(rst), .en(en), .x(x), .pat_load(pat_load), .pat_in(pat_in),
        .overlap(overlap), .y(y), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
    );

    seq_detector_param #(.N(4), .DEF_PAT(4'b1101), .CW(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .x(x), .pat_load(pat_load), .pat_in(pat_in),
        .overlap(overlap), .y(y2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e, input logic b);
        @(negedge clk);
        rst = 1'b0; pat_load = 1'b0; en = e; x = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; x = 1'b0; pat_load = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic load(input logic [3:0] p);
        @(negedge clk);
        pat_load = 1'b1; pat_in = p; en = 1'b1; x = 1'b1;
        @(posedge clk);
        #1;
        pat_load = 1'b0;
    endtask

    initial begin
        logic [6:0] s;
        logic [6:0] e;
        do_reset();
        chk("rst_y", y, 0);
        chk("rst_cnt", match_cnt, 0);
        chk("rst_sat", cnt_sat, 0);
        // 1: all zeros never matches
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0);
            chk($sformatf("zeros_y%0d", i), y, 0);
        end
        chk("zeros_cnt", match_cnt, 0);
        // 2: overlapping 1101101 -> hits after bits 4 and 7
        s = 7'b1101101;
        e = 7'b0001001;
        do_reset();
        overlap = 1'b1;
        for (int i = 6; i >= 0; i--) begin
            step(1'b1, s[i]);
            chk($sformatf("ovl_y_bit%0d", 7 - i), y, e[i]);
        end
        chk("ovl_cnt", match_cnt, 2);
        // 3: non-overlapping, same stream -> single hit
        e = 7'b0001000;
        do_reset();
        overlap = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            step(1'b1, s[i]);
            chk($sformatf("novl_y_bit%0d", 7 - i), y, e[i]);
        end
        chk("novl_cnt", match_cnt, 1);
        // 4: en gap inside the pattern
        do_reset();
        overlap = 1'b1;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        chk("gap_idle_y", y, 0);
        step(1'b1, 1'b0);
        chk("gap_bit3_y", y, 0);
        step(1'b1, 1'b1);
        chk("gap_bit4_y", y, 1);
        step(1'b0, 1'b1);
        chk("gap_after_y", y, 0);
        chk("gap_cnt", match_cnt, 1);
        // 5: pattern load clears window; needs 4 fresh bits
        do_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        load(4'b0110);
        chk("load_y", y, 0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        chk("load_partial_y", y, 0);
        load(4'b0110);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("load_bit3_y", y, 0);
        step(1'b1, 1'b0);
        chk("load_bit4_y", y, 1);
        chk("load_cnt", match_cnt, 1);
        // 6: saturating 2-bit counter, five hits
        do_reset();
        overlap = 1'b1;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("sat_hit1_y", y2, 1);
        chk("sat_hit1_cnt", match_cnt2, 1);
        chk("sat_hit1_sat", cnt_sat2, 0);
        for (int h = 2; h <= 5; h++) begin
            step(1'b1, 1'b1);
            step(1'b1, 1'b0);
            step(1'b1, 1'b1);
            chk($sformatf("sat_hit%0d_cnt", h), match_cnt2, (h >= 3) ? 3 : h);
            chk($sformatf("sat_hit%0d_sat", h), cnt_sat2, (h >= 3) ? 1 : 0);
        end
        chk("wide_cnt5", match_cnt, 5);
        chk("wide_sat5", cnt_sat, 0);
        // rst coinciding with a completing bit wins
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1; en = 1'b1; x = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; en = 1'b0;
        chk("midrst_y", y, 0);
        chk("midrst_y2", y2, 0);
        chk("midrst_cnt", match_cnt, 0);
        chk("midrst_cnt2", match_cnt2, 0);
        chk("midrst_sat2", cnt_sat2, 0);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
